pir_alarm_ctrl: RTL and testbench
=================================

Name: pir_alarm_ctrl

Overview:
Parametrised motion-detection alarm controller, the synthesisable next generation of the three-PIR alarm path. It takes NUM_SENSORS raw PIR inputs plus the system enable (turn) and stop_alarm controls. It synchronises and debounces every sensor, arms after a programmable delay and latches the alarm with per-zone capture. It also adds features the first generation lacks: per-zone masking, alarm auto-timeout and a post-clear hold-off.

Parameters:
NUM_SENSORS, 3, number of PIR channels (1..32)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced motion bit changes (>=1)
ARM_DELAY_CYCLES, 8, cycles from turn rising until armed (>=1)
ALARM_TIMEOUT_CYCLES, 64, alarm auto-clears after this many cycles; 0 = never auto-clear
HOLDOFF_CYCLES, 4, cycles motion is ignored after an alarm clears (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
turn  in  1  system enable; 1 = on, 0 = off (asynchronous to clk, synchronised internally)
stop_alarm  in  1  alarm acknowledge, level sampled each cycle (synchronised internally)
pir_sensor  in  NUM_SENSORS  raw PIR inputs, asynchronous
zone_mask  in  NUM_SENSORS  1 = zone enabled to trigger, quasi-static
motion  out  NUM_SENSORS  debounced sensor levels
armed  out  1  high in ARMED and ALARM states
alarm  out  1  alarm output
alarm_zones  out  NUM_SENSORS  sticky record of zones that triggered the current alarm
state  out  3  current FSM state encoding, for debug

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0, state=OFF, all synchronisers and counters 0.
- Reset has absolute priority, including mid-alarm.
- Synchronisation: pir_sensor, turn and stop_alarm each pass through 2 flops.
- Debounce, per channel: the counter increments while sync != motion and clears when they are equal.
- When the counter reaches DEBOUNCE_CYCLES, motion takes the sync value and the counter clears.
- Debounce latency: if the input changes before edge E and is held, motion updates at edge E+1+DEBOUNCE_CYCLES.
- Debounce filtering: any excursion shorter than DEBOUNCE_CYCLES cycles is ignored.
- trig = motion & zone_mask.
- FSM states: OFF, ARMING, ARMED, ALARM, HOLDOFF. Transitions are evaluated each edge.
  - OFF: when synced turn=1, load arm counter and go to ARMING.
  - ARMING: decrement the counter; at 0 go to ARMED. armed rises exactly ARM_DELAY_CYCLES edges after ARMING entry. turn=0 returns to OFF.
  - ARMED: if |trig, go to ALARM, set alarm=1, alarm_zones=trig and load the timeout counter. turn=0 goes to OFF.
  - ALARM: alarm_zones |= trig every cycle. Exit priority is turn=0 > stop_alarm > timeout.
    - turn=0: go to OFF.
    - stop_alarm=1: go to HOLDOFF.
    - Timeout (counter reaches 0, ALARM_TIMEOUT_CYCLES != 0): go to HOLDOFF.
    - Any exit clears alarm and alarm_zones on the same edge.
  - HOLDOFF: trig is ignored for HOLDOFF_CYCLES, then go to ARMED. If trig is still active on ARMED entry, it re-alarms on the next edge. turn=0 goes to OFF.
- stop_alarm outside ALARM has no effect.
- turn toggling back to 1 while in OFF restarts the full arming delay.
- Alarm latency: trig rising at edge N gives alarm=1 at edge N+1.
- Counters are sized $clog2(max+1) and never wrap: they saturate or stop at 0.
- zone_mask changes in ALARM do not clear already-captured alarm_zones bits.

Decomposition:
- Package pir_alarm_pkg holds:
  - the state enum (OFF=0, ARMING=1, ARMED=2, ALARM=3, HOLDOFF=4);
  - a counter-width helper function;
  - default parameter constants.
- Sub-module pir_debounce, one instance per channel: 2-flop synchroniser plus stable counter, parameter DEBOUNCE_CYCLES, 1-bit in/out. Instantiate it via generate.
- The top level holds the FSM, arm/timeout/hold-off counters and zone capture.

Test Plan:
1. rst=1 for 3 cycles, then turn=1 held with defaults → armed rises exactly 8 edges after ARMING entry; alarm stays 0.
2. Armed, zone_mask=3'b111, pir_sensor=3'b101 held → motion=3'b101 at E+5, alarm=1 and alarm_zones=3'b101 one edge later; then pir_sensor[1]=1 → alarm_zones=3'b111.
3. Armed, pir_sensor[0] pulses for 3 cycles (< DEBOUNCE_CYCLES=4) → motion and alarm stay 0.
4. In ALARM, stop_alarm=1 → alarm and alarm_zones clear; motion is ignored for 4 cycles; if motion is still high, alarm re-asserts on the first edge after HOLDOFF→ARMED.
5. In ALARM with stop_alarm=0 → alarm auto-clears after 64 cycles. With ALARM_TIMEOUT_CYCLES=0, alarm holds indefinitely (check 500 cycles).
6. zone_mask=3'b010 with pir_sensor=3'b101 → no alarm. Then turn=0 mid-ALARM and stop_alarm=1 in the same cycle → state OFF with armed, alarm and alarm_zones all 0. Then rst asserted mid-ARMING → all outputs 0 next edge.

Source files
------------

// File: rtl/pir_alarm_pkg.sv
// Shared definitions for the PIR alarm controller.
//   state_e   : FSM state encoding (also exported on the debug 'state' port)
//   DEF_*     : default parameter values
//   cnt_width : width of a counter that must hold 0..max_val (never zero bits)
package pir_alarm_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ARMING  = 3'd1,
    S_ARMED   = 3'd2,
    S_ALARM   = 3'd3,
    S_HOLDOFF = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_SENSORS          = 3;
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 4;
  localparam int unsigned DEF_ARM_DELAY_CYCLES     = 8;
  localparam int unsigned DEF_ALARM_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_HOLDOFF_CYCLES       = 4;

  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pir_alarm_ctrl_debounce.sv
// Single-channel PIR conditioning: 2-flop synchroniser followed by a
// stability filter. The output only follows the synchronised input once it
// has disagreed with the output for DEBOUNCE_CYCLES consecutive cycles, so
// shorter glitches never reach 'dout'.
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous sensor input
//   dout     : debounced level
module pir_debounce
  import pir_alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d, s2_q, s2_d, mot_q, mot_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = din;
    s2_d  = s1_q;
    mot_d = mot_q;
    cnt_d = '0;
    if (s2_q != mot_q) begin
      // The counter tops out at DEBOUNCE_CYCLES-1; the cycle that would
      // bring it to DEBOUNCE_CYCLES commits the new level and clears it.
      if (cnt_q == LAST) mot_d = s2_q;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      mot_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      mot_q <= mot_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = mot_q;

endmodule

// File: rtl/pir_alarm_ctrl.sv
// Motion alarm controller: per-channel debounce, arming delay, latched alarm
// with per-zone capture, optional auto-timeout and post-clear hold-off.
//   clk, rst     : clock, synchronous active-high reset
//   turn         : system enable (async, synchronised here)
//   stop_alarm   : alarm acknowledge level (async, synchronised here)
//   pir_sensor   : raw PIR inputs
//   zone_mask    : 1 = zone may trigger
//   motion       : debounced sensor levels
//   armed        : high in ARMED and ALARM
//   alarm        : alarm output
//   alarm_zones  : zones that triggered the current alarm (sticky)
//   state        : FSM state, for debug
module pir_alarm_ctrl
  import pir_alarm_pkg::*;
#(
  parameter int unsigned NUM_SENSORS          = DEF_NUM_SENSORS,
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned ARM_DELAY_CYCLES     = DEF_ARM_DELAY_CYCLES,
  parameter int unsigned ALARM_TIMEOUT_CYCLES = DEF_ALARM_TIMEOUT_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES       = DEF_HOLDOFF_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   turn,
  input  logic                   stop_alarm,
  input  logic [NUM_SENSORS-1:0] pir_sensor,
  input  logic [NUM_SENSORS-1:0] zone_mask,
  output logic [NUM_SENSORS-1:0] motion,
  output logic                   armed,
  output logic                   alarm,
  output logic [NUM_SENSORS-1:0] alarm_zones,
  output logic [2:0]             state
);

  localparam int AW = cnt_width(ARM_DELAY_CYCLES);
  localparam int TW = cnt_width(ALARM_TIMEOUT_CYCLES);
  localparam int HW = cnt_width(HOLDOFF_CYCLES);

  // Counters are loaded with N-1 and the exit happens on the edge that sees
  // zero, giving exactly N edges in the state.
  localparam logic [AW-1:0] ARM_INIT  = AW'(ARM_DELAY_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES - 1);
  localparam int unsigned   TMO_M1    =
    (ALARM_TIMEOUT_CYCLES == 0) ? 0 : ALARM_TIMEOUT_CYCLES - 1;
  localparam logic [TW-1:0] TMO_INIT  = TW'(TMO_M1);
  localparam bit            TMO_EN    = (ALARM_TIMEOUT_CYCLES != 0);

  // Per-channel synchronise + debounce
  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    pir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .din  (pir_sensor[i]),
      .dout (motion[i])
    );
  end

  // Control input synchronisers
  logic turn1_q, turn1_d, turn2_q, turn2_d;
  logic stop1_q, stop1_d, stop2_q, stop2_d;

  state_e                   state_q, state_d;
  logic [AW-1:0]            arm_q, arm_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [HW-1:0]            hold_q, hold_d;
  logic [NUM_SENSORS-1:0]   zones_q, zones_d;
  logic [NUM_SENSORS-1:0]   trig;

  assign trig = motion & zone_mask;

  always_comb begin
    turn1_d = turn;
    turn2_d = turn1_q;
    stop1_d = stop_alarm;
    stop2_d = stop1_q;
    state_d = state_q;
    arm_d   = arm_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    zones_d = zones_q;

    case (state_q)
      S_OFF: begin
        if (turn2_q) begin
          state_d = S_ARMING;
          arm_d   = ARM_INIT;
        end
      end
      S_ARMING: begin
        if (!turn2_q)          state_d = S_OFF;
        else if (arm_q == '0)  state_d = S_ARMED;
        else                   arm_d   = arm_q - 1'b1;
      end
      S_ARMED: begin
        if (!turn2_q) state_d = S_OFF;
        else if (|trig) begin
          state_d = S_ALARM;
          zones_d = trig;
          tmo_d   = TMO_INIT;
        end
      end
      S_ALARM: begin
        if (!turn2_q) begin
          state_d = S_OFF;
          zones_d = '0;
        end else if (stop2_q || (TMO_EN && tmo_q == '0)) begin
          state_d = S_HOLDOFF;
          zones_d = '0;
          hold_d  = HOLD_INIT;
        end else begin
          // Capture is sticky: masking a zone later keeps its recorded bit.
          zones_d = zones_q | trig;
          if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (!turn2_q)          state_d = S_OFF;
        else if (hold_q == '0) state_d = S_ARMED;
        else                   hold_d  = hold_q - 1'b1;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      turn1_q <= 1'b0;
      turn2_q <= 1'b0;
      stop1_q <= 1'b0;
      stop2_q <= 1'b0;
      state_q <= S_OFF;
      arm_q   <= '0;
      tmo_q   <= '0;
      hold_q  <= '0;
      zones_q <= '0;
    end else begin
      turn1_q <= turn1_d;
      turn2_q <= turn2_d;
      stop1_q <= stop1_d;
      stop2_q <= stop2_d;
      state_q <= state_d;
      arm_q   <= arm_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      zones_q <= zones_d;
    end
  end

  assign armed       = (state_q == S_ARMED) || (state_q == S_ALARM);
  assign alarm       = (state_q == S_ALARM);
  assign alarm_zones = zones_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// Testbench for pir_alarm_ctrl: directed scenarios plus a randomized phase,
// checked each cycle against a deadline-based reference model.
module tb_pir_alarm_ctrl;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int AD = 8;
  localparam int TO = 64;
  localparam int HO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, turn = 1'b0, stop_alarm = 1'b0;
  logic [N-1:0] pir = '0, mask = '0;

  logic [N-1:0] d_motion, d_zones, z_motion, z_zones;
  logic         d_armed, d_alarm, z_armed, z_alarm;
  logic [2:0]   d_state, z_state;

  pir_alarm_ctrl dut (
    .clk(clk), .rst(rst), .turn(turn), .stop_alarm(stop_alarm),
    .pir_sensor(pir), .zone_mask(mask), .motion(d_motion), .armed(d_armed),
    .alarm(d_alarm), .alarm_zones(d_zones), .state(d_state)
  );

  // Same stimulus, no auto-timeout
  pir_alarm_ctrl #(.ALARM_TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .turn(turn), .stop_alarm(stop_alarm),
    .pir_sensor(pir), .zone_mask(mask), .motion(z_motion), .armed(z_armed),
    .alarm(z_alarm), .alarm_zones(z_zones), .state(z_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timed states are tracked as absolute edge deadlines rather than counters.
  int           cyc = 0;
  int           m_st = 0;          // 0 off,1 arming,2 armed,3 alarm,4 holdoff
  logic [N-1:0] m_mot = '0, m_zones = '0, m_p1 = '0, m_p2 = '0;
  int           m_run [N];
  logic         m_t1 = 0, m_t2 = 0, m_s1 = 0, m_s2 = 0;
  int           arm_at = 0, tmo_at = 0, hold_at = 0;

  task automatic model_step();
    logic [N-1:0] trig;
    int nst;
    cyc++;
    if (rst) begin
      m_st = 0; m_mot = '0; m_zones = '0; m_p1 = '0; m_p2 = '0;
      m_t1 = 0; m_t2 = 0; m_s1 = 0; m_s2 = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      return;
    end
    trig = m_mot & mask;
    nst  = m_st;
    case (m_st)
      0: if (m_t2) begin nst = 1; arm_at = cyc + AD; end
      1: if (!m_t2) nst = 0; else if (cyc == arm_at) nst = 2;
      2: if (!m_t2) nst = 0;
         else if (trig != 0) begin nst = 3; m_zones = trig; tmo_at = cyc + TO; end
      3: if (!m_t2) begin nst = 0; m_zones = '0; end
         else if (m_s2 || (TO != 0 && cyc == tmo_at)) begin
           nst = 4; m_zones = '0; hold_at = cyc + HO;
         end else m_zones = m_zones | trig;
      default: if (!m_t2) nst = 0; else if (cyc == hold_at) nst = 2;
    endcase
    m_st = nst;
    // a level change is accepted after DB consecutive disagreeing samples
    for (int i = 0; i < N; i++) begin
      if (m_p2[i] != m_mot[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin m_mot[i] = m_p2[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_p2 = m_p1; m_p1 = pir;
    m_t2 = m_t1; m_t1 = turn;
    m_s2 = m_s1; m_s1 = stop_alarm;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("m_motion", d_motion, m_mot);
    chk("m_armed",  d_armed,  (m_st == 2 || m_st == 3));
    chk("m_alarm",  d_alarm,  (m_st == 3));
    chk("m_zones",  d_zones,  m_zones);
    chk("m_state",  d_state,  m_st);
  endtask

  initial begin
    int n, c0, c1, e0, hold;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // 1. reset, then arm
    rst = 1; turn = 0; stop_alarm = 0; pir = '0; mask = 3'b111;
    repeat (3) tick();
    chk("rst_state", d_state, 0);
    chk("rst_alarm", {d_armed, d_alarm, d_zones, d_motion}, 0);
    rst = 0; turn = 1;
    n = 0; while (d_state !== 3'd1 && n < 10) begin tick(); n++; end
    chk("arming_seen", d_state, 1);
    c0 = cyc;
    n = 0; while (d_armed !== 1'b1 && n < 20) begin tick(); n++; end
    c1 = cyc;
    chk("arm_delay", c1 - c0, AD);
    chk("arm_noalarm", d_alarm, 0);

    // 3. short pulse is filtered
    pir = 3'b001; repeat (3) tick();
    pir = 3'b000; repeat (10) tick();
    chk("glitch_motion", d_motion, 0);
    chk("glitch_alarm", d_alarm, 0);

    // 2. held motion -> alarm, zones accumulate
    pir = 3'b101; e0 = cyc + 1;
    n = 0; while (d_motion !== 3'b101 && n < 20) begin tick(); n++; end
    chk("db_latency", cyc - e0, DB + 1);
    tick();
    chk("alarm_set", d_alarm, 1);
    chk("zones_101", d_zones, 3'b101);
    pir = 3'b111; repeat (8) tick();
    chk("zones_111", d_zones, 3'b111);

    // 4. acknowledge -> hold-off -> re-alarm with motion still present
    stop_alarm = 1; tick(); stop_alarm = 0;
    n = 0; while (d_alarm !== 1'b0 && n < 8) begin tick(); n++; end
    chk("ack_clear", {d_alarm, d_zones}, 0);
    hold = 0; while (d_alarm !== 1'b1 && hold < 12) begin tick(); hold++; end
    chk("holdoff_len", hold, HO + 1);

    // 5. timeout vs. no timeout
    pir = 3'b000;
    n = 0; while (d_alarm !== 1'b0 && n < 100) begin tick(); n++; end
    chk("timeout_len", n, TO);
    for (int k = 0; k < 500; k++) begin
      tick();
      chk("notimeout_hold", {z_alarm, z_state}, {1'b1, 3'd3});
    end

    // randomized phase
    for (int it = 0; it < 700; it++) begin
      pir = N'($urandom);
      if ($urandom_range(0, 3) == 0) mask = N'($urandom);
      stop_alarm = ($urandom_range(0, 9) == 0);
      turn = ($urandom_range(0, 39) != 0);
      rst  = ($urandom_range(0, 199) == 0);
      n = $urandom_range(1, 7);
      repeat (n) tick();
    end

    // 6. masked zones, simultaneous off+ack, reset mid-arming
    rst = 0; turn = 1; stop_alarm = 0; pir = '0; mask = 3'b010;
    n = 0; while (d_state !== 3'd2 && n < 300) begin tick(); n++; end
    chk("rearmed", d_state, 2);
    pir = 3'b101; repeat (15) tick();
    chk("masked_motion", d_motion, 3'b101);
    chk("masked_noalarm", d_alarm, 0);
    mask = 3'b111;
    n = 0; while (d_alarm !== 1'b1 && n < 5) begin tick(); n++; end
    chk("unmasked_alarm", d_alarm, 1);
    turn = 0; stop_alarm = 1;
    repeat (3) tick();
    chk("off_state", d_state, 0);
    chk("off_outs", {d_armed, d_alarm, d_zones}, 0);
    turn = 1; stop_alarm = 0; pir = '0;
    n = 0; while (d_state !== 3'd1 && n < 6) begin tick(); n++; end
    chk("arming2", d_state, 1);
    tick(); tick();
    rst = 1; tick();
    chk("rst_mid_state", d_state, 0);
    chk("rst_mid_outs", {d_armed, d_alarm, d_zones, d_motion}, 0);
    rst = 0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
